// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core's data-memory port and the responder.
// master = requester (core side), slave = responder.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: latches one request, waits LATENCY
// cycles, commits to a word array, then pulses a one-cycle response.
module dmem_responder #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus,
   output logic             busy
);

   localparam int         WORDS = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT   = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE, WAITING, COMMIT, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        accept;
   logic        acc_err;

   logic [DEPTH_LOG2-1:0] widx;
   logic [31:0]           mem [0:WORDS-1];

   assign accept  = bus.req_valid && (state == IDLE);
   assign widx    = addr_q[DEPTH_LOG2+1:2];
   // Out-of-range is any address bit above the array; those accesses must not alias.
   assign acc_err = (|addr_q[1:0]) || (|addr_q[31:DEPTH_LOG2+2]);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               cnt_nxt   = LAT;
               state_nxt = (LAT == 4'd0) ? COMMIT : WAITING;
            end
         end
         WAITING: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt <= 4'd1) state_nxt = COMMIT;
         end
         COMMIT:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
         end
         if (state == COMMIT) begin
            rdata_q <= (acc_err || we_q) ? 32'd0 : mem[widx];
            err_q   <= acc_err;
         end
      end
   end

   // The array has no reset; an async reset forces IDLE, so an aborted store never lands.
   always_ff @(posedge clk) begin
      if (state == COMMIT && we_q && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign busy           = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic, checked
// against a byte-merging memory model and the request-to-response timing rule.
module tb_dmem_responder;
   localparam int DL2 = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic busy0, busy1;
   logic we = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [3:0] be = '0;
   logic v0 = 1'b0, v1 = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] mdl [int];

   always #5 clk = ~clk;

   dmem_responder_if bus0 ();
   dmem_responder_if bus1 ();

   assign bus0.req_valid = v0;
   assign bus0.req_we    = we;
   assign bus0.req_addr  = addr;
   assign bus0.req_wdata = wdata;
   assign bus0.req_be    = be;
   assign bus1.req_valid = v1;
   assign bus1.req_we    = we;
   assign bus1.req_addr  = addr;
   assign bus1.req_wdata = wdata;
   assign bus1.req_be    = be;

   dmem_responder #(.DEPTH_LOG2(DL2), .LATENCY(2)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .busy(busy0));
   dmem_responder #(.DEPTH_LOG2(DL2), .LATENCY(0)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1), .busy(busy1));

   function automatic int lat_of(input int s);
      return (s != 0) ? 0 : 2;
   endfunction
   function automatic logic rv(input int s);
      return (s != 0) ? bus1.resp_valid : bus0.resp_valid;
   endfunction
   function automatic logic rdy(input int s);
      return (s != 0) ? bus1.req_ready : bus0.req_ready;
   endfunction
   function automatic logic [31:0] rdat(input int s);
      return (s != 0) ? bus1.resp_rdata : bus0.resp_rdata;
   endfunction
   function automatic logic rerr(input int s);
      return (s != 0) ? bus1.resp_err : bus0.resp_err;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Word-organised memory with byte-lane stores; unwritten lanes stay X.
   task automatic model(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output logic er);
      int key;
      logic [31:0] cur;
      er = (a % 4 != 0) || (a >= (32'd4 << DL2));
      rd = 32'd0;
      if (!er) begin
         key = s * 4096 + int'(a / 4);
         cur = mdl.exists(key) ? mdl[key] : 32'hxxxxxxxx;
         if (w) begin
            for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
            mdl[key] = cur;
         end else begin
            rd = cur;
         end
      end
   endtask

   task automatic xact(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input string tag, output logic [31:0] rd);
      int L, waited, lat, pulses, lows;
      logic er;
      logic [31:0] exp_rd;
      logic exp_er;
      L = lat_of(s);
      model(s, w, a, d, b, exp_rd, exp_er);
      @(negedge clk);
      we = w; addr = a; wdata = d; be = b;
      if (s != 0) v1 = 1'b1; else v0 = 1'b1;
      waited = 0;
      while (!rdy(s) && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "/accept"}, 32'(rdy(s)), 32'd1);
      @(negedge clk);
      // Scramble inputs after acceptance; only the latched copy may matter.
      v0 = 1'b0; v1 = 1'b0;
      we = 1'($urandom); addr = $urandom; wdata = $urandom; be = 4'($urandom);
      lat = 0; pulses = 0; lows = 0; rd = 32'd0; er = 1'b0;
      for (int k = 1; k <= L + 3; k++) begin
         if (k > 1) @(negedge clk);
         if (rv(s)) begin
            pulses++;
            lat = k;
            rd = rdat(s);
            er = rerr(s);
         end
         if (!rdy(s)) lows++;
      end
      check({tag, "/pulses"}, 32'(pulses), 32'd1);
      check({tag, "/latency"}, 32'(lat), 32'(L + 2));
      check({tag, "/ready_low"}, 32'(lows), 32'(L + 2));
      check({tag, "/err"}, 32'(er), 32'(exp_er));
      if (!$isunknown(exp_rd)) check({tag, "/rdata"}, rd, exp_rd);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] ea;
      logic [31:0] exp_rd;
      logic exp_er;
      int acc_c[$];
      int resp_c[$];
      logic [31:0] resp_d[$];
      logic [31:0] exp_q[$];
      bit busy_s [0:63];
      int nreq;
      bit change;

      // Reset state
      #12;
      check("rst/resp_valid", 32'(bus0.resp_valid), 32'd0);
      check("rst/rdata", bus0.resp_rdata, 32'd0);
      check("rst/err", 32'(bus0.resp_err), 32'd0);
      check("rst/busy", 32'(busy0), 32'd0);
      check("rst/ready", 32'(bus0.req_ready), 32'd1);
      check("rst/busy1", 32'(busy1), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // 1: store then load back
      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "t1_st", rd);
      check("t1_st/rdata0", rd, 32'd0);
      xact(0, 1'b0, 32'h10, 32'd0, 4'h0, "t1_ld", rd);
      check("t1_ld/value", rd, 32'hDEADBEEF);

      // 2: byte-enable merge
      xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, "t2_st", rd);
      xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "t2_merge", rd);
      xact(0, 1'b0, 32'h20, 32'd0, 4'h0, "t2_ld", rd);
      check("t2_ld/value", rd, 32'h11BB33DD);

      // 3: misaligned and out-of-range accesses
      xact(0, 1'b1, 32'h0, 32'h01020304, 4'hF, "t3_pre", rd);
      xact(0, 1'b0, 32'h22, 32'd0, 4'h0, "t3_mis", rd);
      check("t3_mis/rdata0", rd, 32'd0);
      xact(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, "t3_oor", rd);
      xact(0, 1'b0, 32'h0, 32'd0, 4'h0, "t3_noalias", rd);
      check("t3_noalias/value", rd, 32'h01020304);

      // 4: back-to-back with req_valid held high, alternating store/load
      @(negedge clk);
      nreq = 0; change = 1'b0;
      we = 1'b1; addr = 32'h40; wdata = $urandom; be = 4'hF;
      for (int c = 0; c < 45; c++) begin
         if (change) begin
            nreq++;
            we = (nreq % 2 == 0);
            wdata = $urandom;
            change = 1'b0;
         end
         v0 = (c < 35);
         busy_s[c] = busy0;
         if (rv(0)) begin
            resp_c.push_back(c);
            resp_d.push_back(rdat(0));
         end
         if (v0 && rdy(0)) begin
            model(0, we, addr, wdata, be, exp_rd, exp_er);
            exp_q.push_back(exp_rd);
            acc_c.push_back(c);
            change = 1'b1;
         end
         @(negedge clk);
      end
      v0 = 1'b0;
      check("t4/accepts", 32'(acc_c.size()), 32'd7);
      check("t4/responses", 32'(resp_c.size()), 32'(acc_c.size()));
      for (int i = 0; i < acc_c.size(); i++) begin
         if (i > 0) check("t4/spacing", 32'(acc_c[i] - acc_c[i-1]), 32'd5);
         check("t4/busy_idle", 32'(busy_s[acc_c[i]]), 32'd0);
         for (int j = 1; j <= 4; j++) check("t4/busy_held", 32'(busy_s[acc_c[i] + j]), 32'd1);
         if (i < resp_c.size()) begin
            check("t4/resp_time", 32'(resp_c[i] - acc_c[i]), 32'd4);
            if (!$isunknown(exp_q[i])) check("t4/rdata", resp_d[i], exp_q[i]);
         end
      end

      // 5: reset during WAIT of a store aborts it
      xact(0, 1'b1, 32'h30, 32'd0, 4'hF, "t5_pre", rd);
      xact(0, 1'b0, 32'h10, 32'd0, 4'h0, "t5_ld", rd);
      @(negedge clk);
      we = 1'b1; addr = 32'h30; wdata = 32'hCAFEF00D; be = 4'hF; v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
      check("t5/busy_wait", 32'(busy0), 32'd1);
      reset = 1'b1;
      #1;
      check("t5/resp_valid", 32'(bus0.resp_valid), 32'd0);
      check("t5/rdata", bus0.resp_rdata, 32'd0);
      check("t5/err", 32'(bus0.resp_err), 32'd0);
      check("t5/busy", 32'(busy0), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      xact(0, 1'b0, 32'h30, 32'd0, 4'h0, "t5_noabortwr", rd);
      check("t5_noabortwr/value", rd, 32'd0);

      // 6: zero-latency instance, and a store with no byte enables
      xact(1, 1'b1, 32'h10, 32'h12345678, 4'hF, "t6_st", rd);
      xact(1, 1'b0, 32'h10, 32'd0, 4'h0, "t6_ld", rd);
      check("t6_ld/value", rd, 32'h12345678);
      xact(1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, "t6_be0", rd);
      xact(1, 1'b0, 32'h10, 32'd0, 4'h0, "t6_ld2", rd);
      check("t6_ld2/value", rd, 32'h12345678);

      // Random traffic on both instances
      for (int n = 0; n < 40; n++) begin
         int s;
         int r;
         s = int'($urandom_range(0, 1));
         r = int'($urandom_range(0, 9));
         ea = 32'($urandom_range(0, 15)) * 4;
         if (r == 0) ea = ea | 32'($urandom_range(1, 3));
         if (r == 1) ea = ea | (32'd1 << $urandom_range(10, 31));
         xact(s, 1'($urandom), ea, $urandom, 4'($urandom), "rand", rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
